// File: rtl/game_flow_ctrl.sv
// Frame-level game sequencer: game state, lives, seconds timer and hit freeze.
// All play transitions are sampled on refresh_tick; only the start button acts on any cycle.
module game_flow_ctrl #(
  parameter int LIVES          = 3,
  parameter int HIT_FRAMES     = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_LIMIT     = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       finish,
  output logic [2:0] state,
  output logic       move_en,
  output logic       ball_en,
  output logic       respawn,
  output logic [2:0] lives,
  output logic [9:0] seconds,
  output logic       flash
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [9:0] TIME_LIM   = 10'(TIME_LIMIT);

  logic [2:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [9:0] seconds_q, seconds_d;
  logic [5:0] frame_q, frame_d;
  logic [7:0] hit_q, hit_d;
  logic       respawn_q, respawn_d;
  logic       start_q;
  logic       start_rise;

  assign start_rise = start_btn & ~start_q;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    seconds_d = seconds_q;
    frame_d   = frame_q;
    hit_d     = hit_q;
    respawn_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d   = S_PLAY;
          lives_d   = LIVES_INIT;
          seconds_d = 10'd0;
          frame_d   = 6'd0;
          respawn_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (refresh_tick) begin
          if (finish) begin
            state_d = S_WIN;
          end else if (collision) begin
            respawn_d = 1'b1;
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              hit_d   = 8'd0;
              state_d = S_HIT;
            end else begin
              lives_d = 3'd0;
              state_d = S_OVER;
            end
          end else if (frame_q == FRAME_LAST) begin
            frame_d = 6'd0;
            // Saturate at the limit so the display shows exactly TIME_LIMIT at game over.
            if (seconds_q + 10'd1 >= TIME_LIM) begin
              seconds_d = TIME_LIM;
              state_d   = S_OVER;
            end else begin
              seconds_d = seconds_q + 10'd1;
            end
          end else begin
            frame_d = frame_q + 6'd1;
          end
        end
      end
      S_HIT: begin
        if (refresh_tick) begin
          if (hit_q == HIT_LAST) state_d = S_PLAY;
          else                   hit_d   = hit_q + 8'd1;
        end
      end
      S_WIN, S_OVER: begin
        if (start_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lives_q   <= LIVES_INIT;
      seconds_q <= 10'd0;
      frame_q   <= 6'd0;
      hit_q     <= 8'd0;
      respawn_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      seconds_q <= seconds_d;
      frame_q   <= frame_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
      start_q   <= start_btn;
    end
  end

  assign state   = state_q;
  assign lives   = lives_q;
  assign seconds = seconds_q;
  assign respawn = respawn_q;
  assign move_en = (state_q == S_PLAY);
  assign ball_en = (state_q == S_PLAY) || (state_q == S_HIT);
  assign flash   = (state_q == S_HIT) & hit_q[2];

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: two parameterisations share one stimulus stream,
// a tick-count reference model predicts every cycle and per-DUT monitors compare.
module tb_game_flow_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lives;
    logic [9:0] sec;
    logic       move;
    logic       ball;
    logic       resp;
    logic       flash;
  } obs_t;

  localparam int P_L0 = 3, P_HF0 = 30, P_FPS0 = 60, P_TL0 = 99;
  localparam int P_L1 = 2, P_HF1 = 5,  P_FPS1 = 4,  P_TL1 = 2;

  int p_l[2]   = '{P_L0, P_L1};
  int p_hf[2]  = '{P_HF0, P_HF1};
  int p_fps[2] = '{P_FPS0, P_FPS1};
  int p_tl[2]  = '{P_TL0, P_TL1};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic refresh_tick = 1'b0, start_btn = 1'b0, collision = 1'b0, finish = 1'b0;

  logic [2:0] state0, lives0, state1, lives1;
  logic [9:0] seconds0, seconds1;
  logic       move0, ball0, resp0, flash0, move1, ball1, resp1, flash1;

  game_flow_ctrl #(.LIVES(P_L0), .HIT_FRAMES(P_HF0), .FRAMES_PER_SEC(P_FPS0), .TIME_LIMIT(P_TL0)) u_dut0 (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start_btn(start_btn),
    .collision(collision), .finish(finish), .state(state0), .move_en(move0), .ball_en(ball0),
    .respawn(resp0), .lives(lives0), .seconds(seconds0), .flash(flash0));

  game_flow_ctrl #(.LIVES(P_L1), .HIT_FRAMES(P_HF1), .FRAMES_PER_SEC(P_FPS1), .TIME_LIMIT(P_TL1)) u_dut1 (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start_btn(start_btn),
    .collision(collision), .finish(finish), .state(state1), .move_en(move1), .ball_en(ball1),
    .respawn(resp1), .lives(lives1), .seconds(seconds1), .flash(flash1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 play, 2 hit, 3 win, 4 over; time kept as total ticks played.
  int m_st[2], m_lives[2], m_ticks[2], m_hit[2];
  bit m_resp[2];
  bit m_start_d;

  obs_t q0[$];
  obs_t q1[$];

  function automatic obs_t expect_obs(int i);
    obs_t o;
    o.st    = 3'(m_st[i]);
    o.lives = 3'(m_lives[i]);
    o.sec   = 10'(m_ticks[i] / p_fps[i]);
    o.move  = (m_st[i] == 1);
    o.ball  = (m_st[i] == 1) || (m_st[i] == 2);
    o.resp  = m_resp[i];
    o.flash = (m_st[i] == 2) && (((m_hit[i] / 4) % 2) == 1);
    return o;
  endfunction

  task automatic model_reset(int i);
    m_st[i] = 0; m_lives[i] = p_l[i]; m_ticks[i] = 0; m_hit[i] = 0; m_resp[i] = 1'b0;
  endtask

  task automatic model_step(int i, bit rise, bit tick, bit col, bit fin);
    m_resp[i] = 1'b0;
    case (m_st[i])
      0: if (rise) begin
        m_st[i] = 1; m_lives[i] = p_l[i]; m_ticks[i] = 0; m_resp[i] = 1'b1;
      end
      1: if (tick) begin
        if (fin) m_st[i] = 3;
        else if (col) begin
          m_resp[i] = 1'b1;
          if (m_lives[i] > 1) begin m_lives[i]--; m_st[i] = 2; m_hit[i] = 0; end
          else begin m_lives[i] = 0; m_st[i] = 4; end
        end else begin
          m_ticks[i]++;
          if (m_ticks[i] / p_fps[i] >= p_tl[i]) m_st[i] = 4;
        end
      end
      2: if (tick) begin
        if (m_hit[i] + 1 >= p_hf[i]) m_st[i] = 1;
        else m_hit[i]++;
      end
      default: if (rise) m_st[i] = 0;
    endcase
  endtask

  task automatic compare(string name, obs_t act, obs_t exp_o);
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s t=%0t actual st=%0d lives=%0d sec=%0d mv=%0b bl=%0b rsp=%0b fl=%0b required st=%0d lives=%0d sec=%0d mv=%0b bl=%0b rsp=%0b fl=%0b",
               name, $time, act.st, act.lives, act.sec, act.move, act.ball, act.resp, act.flash,
               exp_o.st, exp_o.lives, exp_o.sec, exp_o.move, exp_o.ball, exp_o.resp, exp_o.flash);
    end
  endtask

  // One clock of stimulus: inputs applied at the falling edge, prediction queued for the next rise.
  task automatic cyc(bit rb, bit btn, bit tick, bit col, bit fin);
    bit rise;
    @(negedge clk);
    reset = rb; start_btn = btn; refresh_tick = tick; collision = col; finish = fin;
    if (!rb) begin
      model_reset(0); model_reset(1); m_start_d = 1'b0;
    end else begin
      rise = btn && !m_start_d;
      m_start_d = btn;
      model_step(0, rise, tick, col, fin);
      model_step(1, rise, tick, col, fin);
    end
    q0.push_back(expect_obs(0));
    q1.push_back(expect_obs(1));
  endtask

  always @(posedge clk) begin
    obs_t e0, e1;
    #2;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      compare("dut0", {state0, lives0, seconds0, move0, ball0, resp0, flash0}, e0);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      compare("dut1", {state1, lives1, seconds1, move1, ball1, resp1, flash1}, e1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit btn;
    obs_t r0, r1;
    model_reset(0); model_reset(1); m_start_d = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (120) cyc(1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 1, 0);
      repeat (35) cyc(1, 0, 1, 0, 0);
    end
    repeat (2) begin
      repeat (3) cyc(1, 1, 0, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0);
    end
    repeat (3) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 1);
    repeat (3) cyc(1, 0, 1, 0, 0);

    btn = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) btn = ~btn;
      cyc(1, btn, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    repeat (3) cyc(1, 0, 1, 0, 0);

    // Mid-hit/mid-play asynchronous reset: outputs must clear before the next clock edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    r0 = '{st: 3'd0, lives: 3'(P_L0), sec: 10'd0, move: 1'b0, ball: 1'b0, resp: 1'b0, flash: 1'b0};
    r1 = '{st: 3'd0, lives: 3'(P_L1), sec: 10'd0, move: 1'b0, ball: 1'b0, resp: 1'b0, flash: 1'b0};
    compare("async_rst0", {state0, lives0, seconds0, move0, ball0, resp0, flash0}, r0);
    compare("async_rst1", {state1, lives1, seconds1, move1, ball1, resp1, flash1}, r1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 1, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (10) cyc(1, 0, 1, 0, 0);

    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
